// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1-to-memory line arbiter: line type, FSM states and
// the port identifiers used for round-robin bookkeeping.
package cache_arbiter_pkg;

  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_LINE_W-1:0] lc3b_block;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

endpackage

// File: rtl/cache_arbiter_rr_pick.sv
// Combinational round-robin chooser between the I-cache and D-cache ports.
// On contention the port that did not win last time is chosen.
module cache_arbiter_rr_pick
  import cache_arbiter_pkg::*;
(
  input  logic      i_req_i,
  input  logic      d_req_i,
  input  arb_port_t last_grant_i,
  output logic      grant_valid_o,
  output arb_port_t grant_port_o
);

  always_comb begin
    grant_valid_o = i_req_i | d_req_i;
    grant_port_o  = PORT_I;
    if (i_req_i && d_req_i) begin
      grant_port_o = (last_grant_i == PORT_I) ? PORT_D : PORT_I;
    end else if (d_req_i) begin
      grant_port_o = PORT_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/write-backs onto one memory line
// port; the winning command is registered and held until memory responds.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

  arb_state_t        state_q;
  arb_port_t         last_grant_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic              read_d;
  logic              write_d;
  logic [ADDR_W-1:0] addr_d;
  logic [LINE_W-1:0] wdata_d;

  logic              grant_valid;
  arb_port_t         grant_port;

  cache_arbiter_rr_pick u_rr_pick (
    .i_req_i       (i_read),
    .d_req_i       (d_read | d_write),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_port_o  (grant_port)
  );

  // Capture values for the winner; a D request with both read and write set
  // is treated as a read.
  always_comb begin
    if (grant_port == PORT_D) begin
      read_d  = d_read;
      write_d = ~d_read;
      addr_d  = d_addr & LINE_MASK;
      wdata_d = d_wdata;
    end else begin
      read_d  = 1'b1;
      write_d = 1'b0;
      addr_d  = i_addr & LINE_MASK;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_I;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            state_q      <= (grant_port == PORT_D) ? SERVE_D : SERVE_I;
            pmem_read_q  <= read_d;
            pmem_write_q <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state_q      <= IDLE;
            last_grant_q <= (state_q == SERVE_D) ? PORT_D : PORT_I;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pmem_read  = pmem_read_q;
  assign pmem_write = pmem_write_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;

  assign i_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_resp  = (state_q == SERVE_D) & pmem_resp;
  // Read data is a pass-through, forced low only while reset is asserted.
  assign i_rdata = rst_n ? pmem_rdata : '0;
  assign d_rdata = rst_n ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a memory responder model, a scoreboard of
// expected responses, and a monitor that checks each resp pulse against it.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  logic        clk, rst_n;
  logic        i_read, d_read, d_write;
  logic [15:0] i_addr, d_addr, pmem_addr;
  lc3b_block   i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
  logic        i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

  int        tests = 0;
  int        fails = 0;
  int        mem_lat = 3;
  int        mem_cnt = 0;
  logic      data_by_addr = 1'b0;
  lc3b_block mem_data = '0;

  typedef struct {
    logic      is_d;
    logic      chk_data;
    lc3b_block data;
  } exp_t;
  exp_t sb_q[$];

  cache_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory model: responds after mem_lat cycles of an asserted command.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        mem_cnt   = 0;
      end else if (rst_n && (pmem_read || pmem_write)) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = data_by_addr ? {8{pmem_addr}} : mem_data;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Monitor: every resp pulse must match the oldest expected response.
  initial begin
    forever begin
      @(negedge clk);
      if (i_resp || d_resp) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("[TB] resp %s rdata=%0h", e.is_d ? "D" : "I", e.is_d ? d_rdata : i_rdata);
          chk("resp_port", 128'({i_resp, d_resp}), e.is_d ? 128'h1 : 128'h2);
          if (e.chk_data) chk("resp_rdata", e.is_d ? d_rdata : i_rdata, e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic is_d, input logic chk_data, input lc3b_block data);
    exp_t e;
    e.is_d = is_d;
    e.chk_data = chk_data;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_resp(output logic got_d);
    int n = 0;
    @(negedge clk);
    while (!(i_resp || d_resp) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(i_resp || d_resp)) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no resp in 100 cycles expected a resp");
    end
    got_d = d_resp;
  endtask

  // Watches one single-port transaction from the cycle its request is driven.
  task automatic txn(input string nm, input logic [15:0] eaddr, input logic erd, input logic ewr,
                     input lc3b_block ewd, input int efirst, input int encmd);
    int   n = 0;
    int   first = -1;
    int   ncmd = 0;
    int   nbad = 0;
    logic done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        if (first < 0) first = n;
        ncmd++;
        if (pmem_addr !== eaddr || pmem_read !== erd || pmem_write !== ewr || pmem_wdata !== ewd)
          nbad++;
      end
      if (i_resp || d_resp) done = 1'b1;
      else n++;
    end
    $display("[TB] txn %s addr=%0h first=%0d cmd_cycles=%0d bad=%0d", nm, eaddr, first, ncmd, nbad);
    chk({nm, "_done"}, 128'(done), 128'h1);
    chk({nm, "_first_cmd"}, 128'(first), 128'(efirst));
    chk({nm, "_cmd_cycles"}, 128'(ncmd), 128'(encmd));
    chk({nm, "_cmd_stable"}, 128'(nbad), 128'h0);
    @(posedge clk);
    #1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_after"}, 128'({pmem_read, pmem_write, i_resp, d_resp}), 128'h0);
  endtask

  // Both ports request; each drops for one cycle after its resp. Grants start with D.
  task automatic rr_run(input int ntx, input logic [15:0] ai, input logic [15:0] ad);
    logic got_d;
    for (int t = 0; t < ntx; t++) begin
      push_exp(t % 2 == 0, 1'b1, (t % 2 == 0) ? {8{ad}} : {8{ai}});
    end
    i_addr = ai; d_addr = ad;
    i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
    for (int t = 0; t < ntx; t++) begin
      wait_resp(got_d);
      $display("[TB] rr transaction %0d served %s", t, got_d ? "D" : "I");
      @(posedge clk);
      #1;
      if (got_d) d_read = 1'b0;
      else i_read = 1'b0;
      @(negedge clk);
      chk("rr_idle_gap", 128'({pmem_read, pmem_write}), 128'h0);
      if (t < ntx - 2) begin
        @(posedge clk);
        #1;
        if (got_d) d_read = 1'b1;
        else i_read = 1'b1;
      end
      if (t < ntx - 1) begin
        @(negedge clk);
        chk("rr_next_cmd", 128'(pmem_read), 128'h1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    #2;
    chk("reset_cmd", 128'({pmem_read, pmem_write, i_resp, d_resp}), 128'h0);
    chk("reset_addr", 128'(pmem_addr), 128'h0);
    chk("reset_wdata", pmem_wdata, 128'h0);
    do_reset();

    // I-cache fill, 3-cycle memory latency
    mem_lat = 3; data_by_addr = 1'b0; mem_data = {16{8'hA5}};
    push_exp(1'b0, 1'b1, {16{8'hA5}});
    i_addr = 16'h1236; i_read = 1'b1;
    txn("ifill", 16'h1230, 1'b1, 1'b0, '0, 1, 3);

    // D-cache write-back, 5-cycle latency
    @(posedge clk); #1;
    mem_lat = 5;
    push_exp(1'b1, 1'b0, '0);
    d_addr = 16'h4000; d_wdata = {4{32'hDEAD_BEEF}}; d_write = 1'b1;
    txn("dwb", 16'h4000, 1'b0, 1'b1, {4{32'hDEAD_BEEF}}, 1, 5);

    // Contention from reset: D, I, D, I
    do_reset();
    mem_lat = 3; data_by_addr = 1'b1;
    rr_run(4, 16'h2000, 16'h3000);

    // Requester changes address and drops its read mid-service
    @(posedge clk); #1;
    mem_lat = 4; data_by_addr = 1'b0; mem_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    push_exp(1'b1, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    d_addr = 16'h5678; d_wdata = 128'h55; d_read = 1'b1;
    @(posedge clk); #1;
    d_addr = 16'hFFF0; d_read = 1'b0;
    txn("dhold", 16'h5670, 1'b1, 1'b0, 128'h55, 0, 4);

    // Read and write together: read wins, offset bits cleared
    @(posedge clk); #1;
    mem_lat = 2; mem_data = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    push_exp(1'b1, 1'b1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    d_addr = 16'h0008; d_wdata = 128'hCAFE; d_read = 1'b1; d_write = 1'b1;
    txn("drw", 16'h0000, 1'b1, 1'b0, 128'hCAFE, 1, 2);

    // Reset in the middle of an I fill abandons it
    @(posedge clk); #1;
    mem_lat = 10;
    i_addr = 16'h1111; i_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_serving", 128'(pmem_read), 128'h1);
    @(posedge clk); #1;
    rst_n = 1'b0; i_read = 1'b0;
    #1;
    chk("rst_mid_cmd", 128'({pmem_read, pmem_write, i_resp, d_resp}), 128'h0);
    chk("rst_mid_addr", 128'(pmem_addr), 128'h0);
    chk("rst_mid_rdata", i_rdata, 128'h0);
    $display("[TB] reset asserted mid-transaction");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_lat = 2; data_by_addr = 1'b1;
    rr_run(2, 16'h8000, 16'h7000);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(sb_q.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits directly downstream of the pipelined datapath's two memory ports, behind the split L1 caches.
- Arbitrates I-cache line fills and D-cache fills/write-backs onto the single shared physical-memory (or L2) line port.
- Registers the winning request's command, address and write data, then holds it stable until memory responds.
- Routes the response back to the winner only.

Parameters:
ADDR_W, 16, byte address width (lc3b_word)
LINE_W, 128, cache line width in bits (8 lc3b_words)
OFFSET_W, 4, line-offset bits forced to zero on the memory address

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_read  in  1  I-cache line fill request, held until i_resp
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  fill data to I-cache
i_resp  out  1  I-cache transaction complete, one-cycle pulse
d_read  in  1  D-cache line fill request, held until d_resp
d_write  in  1  D-cache write-back request, held until d_resp
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write-back data
d_rdata  out  LINE_W  fill data to D-cache
d_resp  out  1  D-cache transaction complete, one-cycle pulse
pmem_read  out  1  memory read command
pmem_write  out  1  memory write command
pmem_addr  out  ADDR_W  memory line address, low OFFSET_W bits zero
pmem_wdata  out  LINE_W  memory write data
pmem_rdata  in  LINE_W  memory read data
pmem_resp  in  1  memory transaction complete

Behaviour:
- Reset: rst_n is asynchronous and active-low.
  - State goes to IDLE and last_grant to I.
  - Captured address, data and op registers clear to 0.
  - All outputs are 0 while rst_n is low.
  - Reset asserted mid-transaction abandons the transaction; no resp is issued.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - No pmem command asserted; i_resp = d_resp = 0.
  - i_req = i_read. d_req = d_read | d_write.
  - Only one request active: go to SERVE_x for that port.
  - Both active: round-robin. Grant the port that is NOT last_grant; after reset D wins first.
  - On the granting edge, capture into registers:
    - op: read or write. d_read && d_write together is a protocol violation; read wins.
    - addr with [OFFSET_W-1:0] forced to 0.
    - wdata: d_wdata for D, 0 for I.
- SERVE_x:
  - pmem_read/pmem_write are driven from the captured op.
  - pmem_addr and pmem_wdata are driven from the captured registers.
  - These outputs stay stable regardless of input changes, including a requester dropping its request early.
- Completion:
  - When pmem_resp = 1 in SERVE_x, x_resp = pmem_resp combinationally in that same cycle; the other port's resp stays 0.
  - Next state is IDLE and last_grant <= x.
- Read data: i_rdata and d_rdata both equal pmem_rdata combinationally. They are valid only when the matching resp is high.
- Latency:
  - Request visible in an IDLE cycle N → pmem command asserted in cycle N+1.
  - Response pulse in the same cycle as pmem_resp.
  - At least one IDLE cycle between back-to-back transactions.
- Requester contract: deassert the request in the cycle after its resp. A request still held in that IDLE cycle is treated as a new transaction.
- pmem_resp while in IDLE is ignored.
- No starvation: with both ports requesting continuously, grants strictly alternate.

Decomposition:
- lc3b_types gains:
  - lc3b_block: LINE_W-bit line type.
  - arb_state_t: enum IDLE/SERVE_I/SERVE_D.
  - arb_port_t: enum PORT_I/PORT_D, for last_grant.
- One sub-module is natural: arb_rr_pick, a combinational round-robin chooser. Inputs i_req, d_req, last_grant; outputs grant_valid, grant_port.
- All registers live in cache_arbiter.

Test Plan:
- Reset, then i_read=1, i_addr=16'h1236; memory responds after 3 cycles with pmem_rdata=128'hA5..A5.
  - Cycle+1: pmem_read=1, pmem_addr=16'h1230.
  - i_resp pulses with i_rdata=128'hA5..A5.
  - d_resp stays 0.
- d_write=1, d_addr=16'h4000, d_wdata=128'hDEAD_BEEF repeated; pmem_resp after 5 cycles.
  - pmem_write=1 for 5 cycles with captured data.
  - d_resp is a single one-cycle pulse.
- Both requests asserted from reset, each held until its resp.
  - Grant order: D, I, D, I.
  - Exactly one IDLE cycle between transactions.
- During SERVE_D, change d_addr to 16'hFFF0 and drop d_read.
  - pmem_addr and pmem_read hold their captured values until pmem_resp.
- d_read=1 and d_write=1 together, d_addr=16'h0008.
  - pmem_read=1, pmem_write=0, pmem_addr=16'h0000.
- Assert rst_n=0 mid-SERVE_I, then release it.
  - All outputs are 0 immediately; state is IDLE.
  - No i_resp pulse.
  - The next simultaneous request grants D first.
